// File: rtl/rvc_pkg.sv
// Shared RV32I opcodes, RVC quadrant/funct3 codes and expander result type for the
// fetch aligner.
package rvc_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;

  localparam logic [2:0] C0_ADDI4SPN = 3'b000;
  localparam logic [2:0] C0_LW       = 3'b010;
  localparam logic [2:0] C0_SW       = 3'b110;
  localparam logic [2:0] C1_ADDI     = 3'b000;
  localparam logic [2:0] C1_JAL      = 3'b001;
  localparam logic [2:0] C1_LI       = 3'b010;
  localparam logic [2:0] C1_LUI      = 3'b011;
  localparam logic [2:0] C1_MISC     = 3'b100;
  localparam logic [2:0] C1_J        = 3'b101;
  localparam logic [2:0] C1_BEQZ     = 3'b110;
  localparam logic [2:0] C1_BNEZ     = 3'b111;
  localparam logic [2:0] C2_SLLI     = 3'b000;
  localparam logic [2:0] C2_LWSP     = 3'b010;
  localparam logic [2:0] C2_MISC     = 3'b100;
  localparam logic [2:0] C2_SWSP     = 3'b110;

  typedef logic [15:0] half_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        illegal;
  } rvc_exp_t;

endpackage

// File: rtl/rvc_expander.sv
// Combinational RV32C -> RV32I expander with illegal-encoding detection.
// Illegal halfwords come out as {16'h0, halfword} with illegal set.
module rvc_expander
  import rvc_pkg::*;
(
  input  half_t    half_i,
  output rvc_exp_t exp_o
);

  half_t       w_h;
  logic [4:0]  w_rd, w_rs2, w_rdp, w_rs1p;
  logic [11:0] w_imm_ci;
  logic [19:0] w_imm_j;
  logic [6:0]  w_b_hi;
  logic [4:0]  w_b_lo;
  logic [31:0] w_instr;
  logic        w_ill;

  assign w_h      = half_i;
  assign w_rd     = w_h[11:7];
  assign w_rs2    = w_h[6:2];
  assign w_rdp    = {2'b01, w_h[4:2]};
  assign w_rs1p   = {2'b01, w_h[9:7]};
  assign w_imm_ci = {{6{w_h[12]}}, w_h[12], w_h[6:2]};
  // JAL field order {imm[20], imm[10:1], imm[11], imm[19:12]}
  assign w_imm_j  = {w_h[12], w_h[8], w_h[10:9], w_h[6], w_h[7], w_h[2], w_h[11], w_h[5:3],
                     w_h[12], {8{w_h[12]}}};
  assign w_b_hi   = {w_h[12], {3{w_h[12]}}, w_h[6:5], w_h[2]};
  assign w_b_lo   = {w_h[11:10], w_h[4:3], w_h[12]};

  always_comb begin
    w_instr = '0;
    w_ill   = 1'b0;
    case (w_h[1:0])
      Q0: begin
        unique case (w_h[15:13])
          C0_ADDI4SPN: begin
            w_instr = {2'b00, w_h[10:7], w_h[12:11], w_h[5], w_h[6], 2'b00, 5'd2, 3'b000,
                       w_rdp, OP_IMM};
            w_ill   = (w_h[12:5] == 8'h00);
          end
          C0_LW: w_instr = {5'b0, w_h[5], w_h[12:10], w_h[6], 2'b00, w_rs1p, 3'b010, w_rdp, LOAD};
          C0_SW: w_instr = {5'b0, w_h[5], w_h[12], w_rdp, w_rs1p, 3'b010, w_h[11:10], w_h[6],
                            2'b00, STORE};
          default: w_ill = 1'b1;
        endcase
      end
      Q1: begin
        unique case (w_h[15:13])
          C1_ADDI: w_instr = {w_imm_ci, w_rd, 3'b000, w_rd, OP_IMM};
          C1_JAL:  w_instr = {w_imm_j, 5'd1, JAL};
          C1_LI:   w_instr = {w_imm_ci, 5'd0, 3'b000, w_rd, OP_IMM};
          C1_LUI: begin
            w_ill = ({w_h[12], w_h[6:2]} == 6'd0);
            if (w_rd == 5'd2) begin
              w_instr = {{2{w_h[12]}}, w_h[12], w_h[4:3], w_h[5], w_h[2], w_h[6], 4'b0000,
                         5'd2, 3'b000, 5'd2, OP_IMM};
            end else begin
              w_instr = {{15{w_h[12]}}, w_h[6:2], w_rd, LUI};
            end
          end
          C1_MISC: begin
            unique case (w_h[11:10])
              2'b00: begin
                w_instr = {7'b0000000, w_h[6:2], w_rs1p, 3'b101, w_rs1p, OP_IMM};
                w_ill   = w_h[12];
              end
              2'b01: begin
                w_instr = {7'b0100000, w_h[6:2], w_rs1p, 3'b101, w_rs1p, OP_IMM};
                w_ill   = w_h[12];
              end
              2'b10: w_instr = {w_imm_ci, w_rs1p, 3'b111, w_rs1p, OP_IMM};
              default: begin
                w_ill = w_h[12];
                unique case (w_h[6:5])
                  2'b00: w_instr = {7'b0100000, w_rdp, w_rs1p, 3'b000, w_rs1p, OP};
                  2'b01: w_instr = {7'b0000000, w_rdp, w_rs1p, 3'b100, w_rs1p, OP};
                  2'b10: w_instr = {7'b0000000, w_rdp, w_rs1p, 3'b110, w_rs1p, OP};
                  default: w_instr = {7'b0000000, w_rdp, w_rs1p, 3'b111, w_rs1p, OP};
                endcase
              end
            endcase
          end
          C1_J:    w_instr = {w_imm_j, 5'd0, JAL};
          C1_BEQZ: w_instr = {w_b_hi, 5'd0, w_rs1p, 3'b000, w_b_lo, BRANCH};
          default: w_instr = {w_b_hi, 5'd0, w_rs1p, 3'b001, w_b_lo, BRANCH};
        endcase
      end
      Q2: begin
        unique case (w_h[15:13])
          C2_SLLI: begin
            w_instr = {7'b0000000, w_h[6:2], w_rd, 3'b001, w_rd, OP_IMM};
            w_ill   = w_h[12];
          end
          C2_LWSP: begin
            w_instr = {4'b0, w_h[3:2], w_h[12], w_h[6:4], 2'b00, 5'd2, 3'b010, w_rd, LOAD};
            w_ill   = (w_rd == 5'd0);
          end
          C2_MISC: begin
            if (!w_h[12]) begin
              if (w_rs2 == 5'd0) begin
                w_instr = {12'd0, w_rd, 3'b000, 5'd0, JALR};
                w_ill   = (w_rd == 5'd0);
              end else begin
                w_instr = {7'b0000000, w_rs2, 5'd0, 3'b000, w_rd, OP};
              end
            end else if (w_rs2 == 5'd0) begin
              if (w_rd == 5'd0) w_instr = {12'd1, 5'd0, 3'b000, 5'd0, SYSTEM};
              else              w_instr = {12'd0, w_rd, 3'b000, 5'd1, JALR};
            end else begin
              w_instr = {7'b0000000, w_rs2, w_rd, 3'b000, w_rd, OP};
            end
          end
          C2_SWSP: w_instr = {4'b0, w_h[8:7], w_h[12], w_rs2, 5'd2, 3'b010, w_h[11:9], 2'b00,
                              STORE};
          default: w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) w_instr = {16'h0000, w_h};
  end

  assign exp_o = '{instr: w_instr, illegal: w_ill};

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Realigns 32-bit fetch words into a mixed 16/32-bit stream and emits expanded instructions.
// Define RVC_FETCH_ALIGNER_STATS_EN to add saturating handshake counters.
module rvc_fetch_aligner
  import rvc_pkg::*;
#(
  parameter int unsigned          RegBits  = 32,
  parameter int unsigned          AddrBits = 32,
  parameter int unsigned          BufDepth = 6,
  parameter logic [AddrBits-1:0]  ResetPc  = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [AddrBits-1:0] flush_pc_i,
  input  logic                fetch_valid_i,
  output logic                fetch_ready_o,
  input  logic [RegBits-1:0]  fetch_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         instr_o,
  output logic [AddrBits-1:0] pc_o,
  output logic                compressed_o,
  output logic                illegal_o
`ifdef RVC_FETCH_ALIGNER_STATS_EN
  ,
  output logic [31:0]         stat_c_count_o,
  output logic [31:0]         stat_i_count_o,
  output logic [31:0]         stat_illegal_count_o
`endif
);

  localparam int unsigned CntW = $clog2(BufDepth + 1);

  half_t               r_buf [BufDepth];
  half_t               w_buf_d [BufDepth];
  logic [CntW-1:0]     r_count, w_keep, w_count_d, w_pop_n, w_push_n;
  logic                r_drop_low, r_fetch_ready;
  logic [AddrBits-1:0] r_next_pc, r_pc;
  logic                r_out_valid, r_compressed, r_illegal;
  logic [31:0]         r_instr;
  logic                w_head_is32, w_complete, w_load, w_push;
  half_t               w_push_h0, w_push_h1;
  rvc_exp_t            w_exp;

  rvc_expander u_expander (
    .half_i (r_buf[0]),
    .exp_o  (w_exp)
  );

  always_comb begin
    w_head_is32 = (r_buf[0][1:0] == 2'b11);
    w_complete  = (r_count >= CntW'(1)) && (!w_head_is32 || (r_count >= CntW'(2)));
    w_load      = (!r_out_valid || out_ready_i) && w_complete && !flush_i;
    w_push      = fetch_valid_i && r_fetch_ready && !flush_i;
    w_pop_n     = w_load ? (w_head_is32 ? CntW'(2) : CntW'(1)) : '0;
    w_push_n    = w_push ? (r_drop_low ? CntW'(1) : CntW'(2)) : '0;
    w_push_h0   = r_drop_low ? fetch_data_i[31:16] : fetch_data_i[15:0];
    w_push_h1   = fetch_data_i[31:16];
    w_keep      = r_count - w_pop_n;
    w_count_d   = flush_i ? '0 : w_keep + w_push_n;
    // Shift survivors down to slot 0, then append pushed halfwords after them
    for (int i = 0; i < BufDepth; i++) begin
      w_buf_d[i] = r_buf[i];
      if (i < int'(w_keep)) begin
        if (i + int'(w_pop_n) < BufDepth) w_buf_d[i] = r_buf[i + int'(w_pop_n)];
      end else if (i == int'(w_keep)) begin
        w_buf_d[i] = w_push_h0;
      end else if (i == int'(w_keep) + 1) begin
        w_buf_d[i] = w_push_h1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_count       <= '0;
      r_drop_low    <= 1'b0;
      r_next_pc     <= ResetPc;
      r_fetch_ready <= 1'b0;
      r_out_valid   <= 1'b0;
      r_instr       <= '0;
      r_pc          <= ResetPc;
      r_compressed  <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_count       <= w_count_d;
      r_buf         <= w_buf_d;
      r_fetch_ready <= (w_count_d <= CntW'(BufDepth - 2));
      if (flush_i) begin
        r_next_pc   <= {flush_pc_i[AddrBits-1:1], 1'b0};
        r_drop_low  <= flush_pc_i[1];
        r_out_valid <= 1'b0;
      end else begin
        if (w_push) r_drop_low <= 1'b0;
        if (w_load) begin
          r_out_valid  <= 1'b1;
          r_pc         <= r_next_pc;
          r_next_pc    <= r_next_pc + (w_head_is32 ? AddrBits'(4) : AddrBits'(2));
          r_instr      <= w_head_is32 ? {r_buf[1], r_buf[0]} : w_exp.instr;
          r_compressed <= !w_head_is32;
          r_illegal    <= !w_head_is32 && w_exp.illegal;
        end else if (out_ready_i) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign fetch_ready_o = r_fetch_ready;
  assign out_valid_o   = r_out_valid;
  assign instr_o       = r_instr;
  assign pc_o          = r_pc;
  assign compressed_o  = r_compressed;
  assign illegal_o     = r_illegal;

`ifdef RVC_FETCH_ALIGNER_STATS_EN
  logic [31:0] r_stat_c, r_stat_i, r_stat_ill;
  logic        w_out_hs;

  assign w_out_hs = r_out_valid && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stat_c   <= '0;
      r_stat_i   <= '0;
      r_stat_ill <= '0;
    end else if (w_out_hs) begin
      if (r_compressed && r_stat_c != '1) r_stat_c <= r_stat_c + 32'd1;
      if (!r_compressed && r_stat_i != '1) r_stat_i <= r_stat_i + 32'd1;
      if (r_illegal && r_stat_ill != '1) r_stat_ill <= r_stat_ill + 32'd1;
    end
  end

  assign stat_c_count_o       = r_stat_c;
  assign stat_i_count_o       = r_stat_i;
  assign stat_illegal_count_o = r_stat_ill;
`endif

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Scoreboard bench for rvc_fetch_aligner: directed fetch words, queued expectations,
// negedge monitor popping on every output handshake.
module tb_rvc_fetch_aligner;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
    logic        ill;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_ni, flush_i, fetch_valid_i, out_ready_i;
  logic [31:0] flush_pc_i, fetch_data_i;
  logic        fetch_ready_o, out_valid_o, compressed_o, illegal_o;
  logic [31:0] instr_o, pc_o;
`ifdef RVC_FETCH_ALIGNER_STATS_EN
  logic [31:0] stat_c_count_o, stat_i_count_o, stat_illegal_count_o;
`endif

  int  checks = 0;
  int  errors = 0;
  sb_t exp_q[$];

  logic [15:0] tv_h [16];
  logic [31:0] tv_e [16];
  logic        tv_ill [16];

  always #5 clk = ~clk;

  rvc_fetch_aligner dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .flush_pc_i    (flush_pc_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .fetch_data_i  (fetch_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .compressed_o  (compressed_o),
    .illegal_o     (illegal_o)
`ifdef RVC_FETCH_ALIGNER_STATS_EN
    ,
    .stat_c_count_o       (stat_c_count_o),
    .stat_i_count_o       (stat_i_count_o),
    .stat_illegal_count_o (stat_illegal_count_o)
`endif
  );

  // Monitor: a handshake completes at the next posedge when valid&&ready at negedge
  always @(negedge clk) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got instr=%h pc=%h c=%b ill=%b, want no output",
                 instr_o, pc_o, compressed_o, illegal_o);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        if (instr_o !== e.instr || pc_o !== e.pc || compressed_o !== e.c ||
            illegal_o !== e.ill) begin
          errors++;
          $display("FAIL out_pc_%h: got instr=%h pc=%h c=%b ill=%b, want instr=%h pc=%h c=%b ill=%b",
                   e.pc, instr_o, pc_o, compressed_o, illegal_o, e.instr, e.pc, e.c, e.ill);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic expect_out(input logic [31:0] instr, input logic [31:0] pc, input logic c,
                            input logic ill);
    exp_q.push_back('{instr: instr, pc: pc, c: c, ill: ill});
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    fetch_valid_i = 1'b1;
    fetch_data_i  = w;
    @(negedge clk);
    while (!fetch_ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!fetch_ready_o) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got ready=0 for 50 cycles, want ready=1");
    end
    @(posedge clk);
    #1;
    fetch_valid_i = 1'b0;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush_i    = 1'b1;
    flush_pc_i = pc;
    tick();
    flush_i    = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d outputs pending, want 0", tag, exp_q.size());
    end
  endtask

  initial begin
    tv_h   = '{16'h4505, 16'h0040, 16'h40C8, 16'hBFFD, 16'hC401, 16'h952E, 16'h9002, 16'h4002,
               16'h1502, 16'h8505, 16'hC0C8, 16'h757D, 16'h717D, 16'h8082, 16'h852E, 16'h2011};
    tv_e   = '{32'h00100513, 32'h00410413, 32'h0044A503, 32'hFFFFF06F, 32'h00040463,
               32'h00B50533, 32'h00100073, 32'h00004002, 32'h00001502, 32'h40155513,
               32'h00A4A223, 32'hFFFFF537, 32'hFF010113, 32'h00008067, 32'h00B00533,
               32'h004000EF};
    tv_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_ni = 1'b0; flush_i = 1'b0; flush_pc_i = '0; fetch_valid_i = 1'b0;
    fetch_data_i = '0; out_ready_i = 1'b1;
    repeat (3) tick();
    check("rst_valid", {31'b0, out_valid_o}, 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_flags", {30'b0, compressed_o, illegal_o}, 32'd0);
    check("rst_fetch_ready", {31'b0, fetch_ready_o}, 32'd0);
    rst_ni = 1'b1;
    tick();

    // Two compressed NOPs from one word
    expect_out(32'h00000013, 32'h0, 1'b1, 1'b0);
    expect_out(32'h00000013, 32'h2, 1'b1, 1'b0);
    send_word(32'h0001_0001);
    wait_drain("nop_pair");

    // Straddling 32-bit instruction, then an all-zero illegal halfword
    do_flush(32'h0);
    expect_out(32'h00000013, 32'h0, 1'b1, 1'b0);
    expect_out(32'h00000513, 32'h2, 1'b0, 1'b0);
    expect_out(32'h00000000, 32'h6, 1'b1, 1'b1);
    send_word(32'h0513_0001);
    send_word(32'h0000_0000);
    wait_drain("straddle");

    // Odd-halfword redirect: low half of the word is dropped
    do_flush(32'h102);
    expect_out(32'h00100513, 32'h102, 1'b1, 1'b0);
    send_word(32'h4505_DEAD);
    wait_drain("drop_low");

    // Backpressure: outputs hold, fetch_ready falls, nothing lost on release
    out_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) expect_out(32'h00000013, 32'h104 + 2 * i, 1'b1, 1'b0);
    repeat (3) send_word(32'h0001_0001);
    repeat (3) tick();
    check("hold_valid", {31'b0, out_valid_o}, 32'd1);
    check("hold_instr", instr_o, 32'h00000013);
    check("hold_pc", pc_o, 32'h104);
    check("hold_c", {31'b0, compressed_o}, 32'd1);
    check("hold_fetch_ready", {31'b0, fetch_ready_o}, 32'd0);
    tick();
    check("hold_pc_later", pc_o, 32'h104);
    out_ready_i = 1'b1;
    wait_drain("backpressure");

    // Flush together with fetch and output handshakes
    out_ready_i = 1'b0;
    expect_out(32'h00000013, 32'h110, 1'b1, 1'b0);
    send_word(32'h0001_0001);
    repeat (2) tick();
    out_ready_i   = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h0001_0001;
    flush_i       = 1'b1;
    flush_pc_i    = 32'h200;
    @(negedge clk);
    check("flush_pre_fetch_ready", {31'b0, fetch_ready_o}, 32'd1);
    check("flush_pre_out_valid", {31'b0, out_valid_o}, 32'd1);
    tick();
    fetch_valid_i = 1'b0;
    flush_i       = 1'b0;
    repeat (4) tick();
    check("flush_no_output", {31'b0, out_valid_o}, 32'd0);
    check("flush_queue_empty", exp_q.size(), 32'd0);
    expect_out(32'h00000013, 32'h200, 1'b1, 1'b0);
    expect_out(32'h00000013, 32'h202, 1'b1, 1'b0);
    send_word(32'h0001_0001);
    wait_drain("after_flush");

    // Expansion table, followed by an aligned 32-bit instruction
    do_flush(32'h300);
    for (int i = 0; i < 16; i++) expect_out(tv_e[i], 32'h300 + 2 * i, 1'b1, tv_ill[i]);
    expect_out(32'h00B50533, 32'h320, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) send_word({tv_h[2*k+1], tv_h[2*k]});
    send_word(32'h00B50533);
    wait_drain("expand_table");

    // Mid-stream reset
    out_ready_i = 1'b0;
    send_word(32'h0001_0001);
    repeat (2) tick();
    rst_ni = 1'b0;
    tick();
    check("mrst_valid", {31'b0, out_valid_o}, 32'd0);
    check("mrst_instr", instr_o, 32'd0);
    check("mrst_pc", pc_o, 32'd0);
    check("mrst_flags", {30'b0, compressed_o, illegal_o}, 32'd0);
    check("mrst_fetch_ready", {31'b0, fetch_ready_o}, 32'd0);
`ifdef RVC_FETCH_ALIGNER_STATS_EN
    check("mrst_stat_c", stat_c_count_o, 32'd0);
    check("mrst_stat_i", stat_i_count_o, 32'd0);
    check("mrst_stat_ill", stat_illegal_count_o, 32'd0);
`endif
    rst_ni      = 1'b1;
    out_ready_i = 1'b1;
    expect_out(32'h00000013, 32'h0, 1'b1, 1'b0);
    expect_out(32'h00000013, 32'h2, 1'b1, 1'b0);
    send_word(32'h0001_0001);
    wait_drain("after_reset");
`ifdef RVC_FETCH_ALIGNER_STATS_EN
    check("stat_c_final", stat_c_count_o, 32'd2);
    check("stat_i_final", stat_i_count_o, 32'd0);
    check("stat_ill_final", stat_illegal_count_o, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
